// File: rtl/jtoutrun_obj_lbuf_if.sv
// Bus between the object renderer/mixer and the double-buffered object line buffer.
// Strobes (bf_we, pxl_cen, hstart) are single-cycle qualifiers sampled on clk; there is no backpressure.
interface jtoutrun_obj_lbuf_if;
    logic        pxl_cen;
    logic        hstart;
    logic [13:0] bf_data;
    logic        bf_we;
    logic [8:0]  bf_addr;
    logic [8:0]  hdump;
    logic [13:0] pxl;
    logic        init_busy;
    logic        dbg_state;

    modport master (
        output pxl_cen, hstart, bf_data, bf_we, bf_addr, hdump,
        input  pxl, init_busy, dbg_state
    );

    modport slave (
        input  pxl_cen, hstart, bf_data, bf_we, bf_addr, hdump,
        output pxl, init_busy, dbg_state
    );
endinterface

// File: rtl/jtoutrun_obj_lbuf.sv
// Object line buffer: two 512x14 banks swapped on hstart, display reads clear behind themselves.
// Optional JTOUTRUN_OBJ_PRIO_CMP_EN turns draw writes into a priority-checked read-modify-write.
module jtoutrun_obj_lbuf (
    input  logic               clk,
    input  logic               rst,
    jtoutrun_obj_lbuf_if.slave bus
);
    localparam logic [13:0] TRANSP = 14'h3FFF;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [8:0]  sweep_cnt;
    logic        dsp;
    logic        run;
    logic        wr_bank;
    logic [13:0] mem [0:1023];
    logic        rd_valid;
    logic        rd_bank;
    logic [8:0]  rd_addr;
    logic [13:0] pxl_q;
    logic        dw_en;
    logic [9:0]  dw_idx;
    logic [13:0] dw_data;

    assign run     = (state_q == ST_RUN);
    // Writes in the hstart cycle already belong to the bank that becomes the draw bank.
    assign wr_bank = ~(dsp ^ bus.hstart);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (sweep_cnt == 9'd511) state_d = ST_RUN;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            sweep_cnt <= 9'd0;
            dsp       <= 1'b0;
            rd_valid  <= 1'b0;
            rd_bank   <= 1'b0;
            rd_addr   <= 9'd0;
            pxl_q     <= TRANSP;
        end else begin
            state_q  <= state_d;
            if (!run) sweep_cnt <= sweep_cnt + 9'd1;
            if (run && bus.hstart) dsp <= ~dsp;
            rd_valid <= run & bus.pxl_cen;
            if (run && bus.pxl_cen) begin
                rd_addr <= bus.hdump;
                rd_bank <= dsp;
            end
            if (!run)          pxl_q <= TRANSP;
            else if (rd_valid) pxl_q <= mem[{rd_bank, rd_addr}];
        end
    end

`ifdef JTOUTRUN_OBJ_PRIO_CMP_EN
    logic        s1_valid;
    logic        s1_bank;
    logic [8:0]  s1_addr;
    logic [13:0] s1_data;
    logic [13:0] s1_stored;
    logic        s1_commit;
    logic [13:0] s1_result;
    logic [13:0] cur_stored;

    // Transparent slots always accept; otherwise the newcomer needs equal or higher priority.
    assign s1_commit  = s1_valid &&
                        ((s1_stored[3:0] == 4'hF) || (s1_data[5:4] >= s1_stored[5:4]));
    assign s1_result  = s1_commit ? s1_data : s1_stored;
    assign cur_stored = (s1_valid && (s1_bank == wr_bank) && (s1_addr == bus.bf_addr))
                        ? s1_result : mem[{wr_bank, bus.bf_addr}];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_bank   <= 1'b0;
            s1_addr   <= 9'd0;
            s1_data   <= 14'd0;
            s1_stored <= 14'd0;
        end else begin
            s1_valid <= run & bus.bf_we;
            if (run && bus.bf_we) begin
                s1_bank   <= wr_bank;
                s1_addr   <= bus.bf_addr;
                s1_data   <= bus.bf_data;
                s1_stored <= cur_stored;
            end
        end
    end

    assign dw_en   = s1_commit;
    assign dw_idx  = {s1_bank, s1_addr};
    assign dw_data = s1_data;
`else
    assign dw_en   = run & bus.bf_we;
    assign dw_idx  = {wr_bank, bus.bf_addr};
    assign dw_data = bus.bf_data;
`endif

    // Draw write is last so it wins if a late display clear hits the same entry.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[{1'b0, sweep_cnt}] <= TRANSP;
            mem[{1'b1, sweep_cnt}] <= TRANSP;
        end else begin
            if (rd_valid) mem[{rd_bank, rd_addr}] <= TRANSP;
            if (dw_en)    mem[dw_idx] <= dw_data;
        end
    end

    assign bus.pxl       = pxl_q;
    assign bus.init_busy = ~run;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_jtoutrun_obj_lbuf.sv
// Scoreboard bench for jtoutrun_obj_lbuf: directed writes, line swaps and display reads.
module tb_jtoutrun_obj_lbuf;
    localparam logic [13:0] TRANSP = 14'h3FFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtoutrun_obj_lbuf_if bus();

    jtoutrun_obj_lbuf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [13:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  rd_pipe;

    function automatic void chk(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Track issued reads so the monitor knows when pxl carries a fresh result.
    always @(posedge clk or posedge rst) begin
        if (rst) rd_pipe <= 2'b00;
        else     rd_pipe <= {rd_pipe[0], bus.pxl_cen};
    end

    always @(negedge clk) begin
        if (rd_pipe[1]) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pxl_unexpected actual=%h expected=none", bus.pxl);
            end else begin
                chk("pxl", bus.pxl, exp_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [8:0] addr, input logic [13:0] data);
        bus.bf_we   = 1'b1;
        bus.bf_addr = addr;
        bus.bf_data = data;
        @(negedge clk);
        bus.bf_we   = 1'b0;
    endtask

    task automatic line();
        bus.hstart = 1'b1;
        @(negedge clk);
        bus.hstart = 1'b0;
    endtask

    task automatic rd(input logic [8:0] addr, input logic [13:0] exp);
        bus.pxl_cen = 1'b1;
        bus.hdump   = addr;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.pxl_cen = 1'b0;
    endtask

    task automatic sweep_wait(input string name);
        int n;
        n = 0;
        while (bus.init_busy === 1'b1 && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 14'(n), 14'd512);
        @(negedge clk);
    endtask

    task automatic read_both_banks();
        for (int a = 0; a < 512; a++) rd(9'(a), TRANSP);
        idle(3);
        line();
        for (int a = 0; a < 512; a++) rd(9'(a), TRANSP);
        idle(3);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [13:0] prio_exp;
        bus.pxl_cen = 1'b0;
        bus.hstart  = 1'b0;
        bus.bf_we   = 1'b0;
        bus.bf_addr = 9'd0;
        bus.bf_data = 14'd0;
        bus.hdump   = 9'd0;

        // Reset state and power-up sweep length
        idle(3);
        chk("init_busy_rst", 14'(bus.init_busy), 14'h1);
        chk("pxl_rst", bus.pxl, TRANSP);
        rst = 1'b0;
        sweep_wait("sweep_len");
        read_both_banks();

        // Write, swap, read; a second pair of swaps finds the entry cleared
        wr(9'h010, 14'h1235);
        line();
        rd(9'h010, 14'h1235);
        idle(3);
        line();
        line();
        rd(9'h010, TRANSP);
        idle(3);

        // Write in the hstart cycle lands in the next line, not the current one
        bus.hstart  = 1'b1;
        bus.bf_we   = 1'b1;
        bus.bf_addr = 9'h1FF;
        bus.bf_data = 14'h0001;
        @(negedge clk);
        bus.hstart  = 1'b0;
        bus.bf_we   = 1'b0;
        rd(9'h1FF, TRANSP);
        idle(3);
        line();
        rd(9'h1FF, 14'h0001);
        idle(3);

        // Read issued the clk before hstart completes on the old bank and clears it
        wr(9'h020, 14'h0ABC);
        idle(2);
        line();
        rd(9'h020, 14'h0ABC);
        line();
        idle(3);
        line();
        rd(9'h020, TRANSP);
        idle(3);

        // Back-to-back same-address writes: prio 2 then prio 1
        wr(9'h005, 14'h0021);
        wr(9'h005, 14'h0012);
        idle(2);
        line();
`ifdef JTOUTRUN_OBJ_PRIO_CMP_EN
        prio_exp = 14'h0021;
`else
        prio_exp = 14'h0012;
`endif
        rd(9'h005, prio_exp);
        idle(3);

        // Back-to-back burst with no stall
        wr(9'h100, 14'h0080);
        wr(9'h101, 14'h0111);
        wr(9'h102, 14'h01A2);
        wr(9'h103, 14'h0233);
        wr(9'h104, 14'h02C4);
        wr(9'h105, 14'h0355);
        wr(9'h106, 14'h03E6);
        wr(9'h107, 14'h0407);
        idle(2);
        line();
        rd(9'h100, 14'h0080);
        rd(9'h101, 14'h0111);
        rd(9'h102, 14'h01A2);
        rd(9'h103, 14'h0233);
        rd(9'h104, 14'h02C4);
        rd(9'h105, 14'h0355);
        rd(9'h106, 14'h03E6);
        rd(9'h107, 14'h0407);
        idle(3);

        // Reset in the middle of a write burst
        bus.bf_we   = 1'b1;
        bus.bf_addr = 9'h040;
        bus.bf_data = 14'h0246;
        idle(2);
        bus.bf_addr = 9'h041;
        rst = 1'b1;
        idle(3);
        chk("init_busy_midrst", 14'(bus.init_busy), 14'h1);
        chk("pxl_midrst", bus.pxl, TRANSP);
        bus.bf_we = 1'b0;
        rst = 1'b0;
        sweep_wait("sweep_len_midrst");
        read_both_banks();

        idle(3);
        chk("exp_q_empty", 14'(exp_q.size()), 14'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
